conv_row_assembler: RTL and testbench
=====================================

# conv_row_assembler

Sequential collector on the output side of the receptive-field selector. It scans the selector's address space by driving `rowNumber`/`column` in row-major, half-row order. It captures each returned half-row of convolution results through a valid/ready handshake. It assembles them into a flattened (H-F+1)×(W-F+1) output feature map, which it holds for the next layer, and signals completion with a one-cycle `done`.

## Interface
- `DATA_WIDTH`, 16: width of one output pixel.
- `H`, 32: input image height; output height OH = H-F+1.
- `W`, 32: input image width; output width OW = W-F+1, must be even.
- `F`, 5: filter size; half-row length HALF = OW/2.

- `clk`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low.
- `start`: input, 1 bit. Begins a scan. Sampled only in IDLE.
- `rowNumber`: output, 6 bits. Current output row, 0..OH-1.
- `column`: output, 6 bits. Current half start, 0 or HALF.
- `in_valid`: input, 1 bit. A half-row of results is present on `in_data`.
- `in_ready`: output, 1 bit. High only in RUN.
- `in_data`: input, HALF*DATA_WIDTH bits. Element j (bits j*DATA_WIDTH +: DATA_WIDTH) is the output pixel at column `column`+j.
- `busy`: output, 1 bit. High in RUN and DONE.
- `done`: output, 1 bit. One-cycle pulse when the map is complete.
- `fmap`: output, OH*OW*DATA_WIDTH bits. Pixel (r,c) is at bits (r*OW+c)*DATA_WIDTH.

## Operation
- States:
  - IDLE: `start`=1 → RUN; row and half counters cleared.
  - RUN: stays in RUN until the last beat is accepted, then → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- Beat accept condition: `in_valid` && `in_ready`. On accept:
  - Write `in_data` into `fmap` at pixel offset rowNumber*OW + column.
  - Advance `column`: 0 → HALF → 0. The row increments on the HALF → 0 wrap.
- Last beat: rowNumber=OH-1, column=HALF. No further writes after it.
- `in_valid` low: hold counters and `fmap`. Indefinite stalls are legal.
- `in_data` is ignored whenever it is not accepted, including in IDLE and DONE.
- `start` in RUN or DONE: ignored.
- `start` held high through DONE: a new scan begins on the IDLE cycle that follows.
- `fmap` is not cleared by `start`. Each location is overwritten as its beat is accepted. The previous map stays readable until overwritten.
- Arithmetic:
  - Counters are 6-bit.
  - Legal parameter range: H ≤ 64 and W ≤ 64.
  - The write offset is computed at the width of clog2(OH*OW)+1. No truncation is allowed.

## Timing
- Reset values: state IDLE, `rowNumber`=0, `column`=0, `in_ready`=0, `busy`=0, `done`=0, `fmap`=0.
- `start` sampled at edge 0 → RUN from cycle 1, with `rowNumber`=0, `column`=0, `in_ready`=1.
- Zero-latency accept: the beat accepted at edge k appears in `fmap` after edge k. The counters advance at the same edge.
- With `in_valid` held high: 2*OH beats (56 at defaults) are accepted at edges 1..56, `done`=1 in cycle 57, and the block is IDLE in cycle 58.
- `rowNumber`/`column` are registered and change only on accept. They are stable while a beat is pending, so a combinational selector settles within that cycle.
- Reset asserted mid-scan: the block returns to IDLE immediately and `fmap` is cleared. The partial map is lost, and no `done` is issued.
- Reset deasserted: operation starts at the first rising edge after deassertion. The bench deasserts reset away from clock edges.

## Structure
- Shared package `cnn_pkg` holds:
  - default `DATA_WIDTH`;
  - functions computing OH, OW, HALF and the offset width;
  - the state enum `{IDLE, RUN, DONE}`.
- One sub-module, `rf_scan_counter`: row/half counter with enable, clear, and a last flag. It is reusable by other layers' scanners.
- The `fmap` register array and the write demux stay in the top level.

## Test plan
- Reset, then check idle outputs: all outputs are 0; `in_data`=all-ones with `in_valid`=1 is not written, so `fmap` stays 0.
- Full scan at defaults, `in_valid` always 1, beat n carries element j = n*HALF + j. Required:
  - `done` high exactly in cycle 57;
  - `fmap` pixel (r,c) = r*28+c, the identity ramp;
  - `busy` low in cycle 58.
- Random `in_valid` gaps (30% idle cycles) with the same data. Required:
  - identical final `fmap`;
  - `rowNumber`/`column` never change on a non-accept cycle;
  - `done` is a single pulse.
- `start` pulsed at RUN beat 10 and during DONE: ignored, with no counter reset. `start` held continuously: back-to-back scans with one IDLE cycle between them.
- Reset asserted at beat 30, then a new full scan with data + 0x100. Required:
  - `done` is absent for the aborted run;
  - all outputs read 0 on reset;
  - final `fmap` is the ramp + 0x100.
- Parameter sweep H=W=12, F=5 (OW=8, HALF=4): 16 beats, `done` in cycle 17, `column` toggles between 0 and 4, ramp map correct.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: default pixel width, output geometry helpers, scanner state.
// Latency: n/a (package only).
// Backpressure: n/a.
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Output height of a valid (unpadded, stride 1) convolution.
  function automatic int calc_oh(input int h, input int f);
    return h - f + 1;
  endfunction

  // Output width of a valid (unpadded, stride 1) convolution.
  function automatic int calc_ow(input int w, input int f);
    return w - f + 1;
  endfunction

  // Pixels delivered per beat; output rows arrive as two halves.
  function automatic int calc_half(input int w, input int f);
    return calc_ow(w, f) / 2;
  endfunction

  // Pixel-offset width with one spare bit so row*OW+col never truncates.
  function automatic int calc_off_w(input int h, input int w, input int f);
    return $clog2(calc_oh(h, f) * calc_ow(w, f)) + 1;
  endfunction

endpackage

// File: rtl/conv_row_assembler_if.sv
// Selector-to-assembler half-row channel: scan address out, half-row of results back.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake; data must hold while in_valid && !in_ready.
// Ports: rowNumber/column (scan address), in_valid/in_ready (handshake), in_data (HALF pixels).
interface conv_row_assembler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int HALF       = 14
);
  logic [5:0]                 rowNumber;
  logic [5:0]                 column;
  logic                       in_valid;
  logic                       in_ready;
  logic [HALF*DATA_WIDTH-1:0] in_data;

  // master: the assembler, which walks the address space and sinks results
  modport master (output rowNumber, output column, output in_ready,
                  input  in_valid,  input  in_data);
  // slave: the receptive-field selector (or a bench standing in for it)
  modport slave  (input  rowNumber, input  column, input  in_ready,
                  output in_valid,  output in_data);
endinterface

// File: rtl/rf_scan_counter.sv
// Row/half-row scan counter: walks (row, 0) -> (row, HALF) -> (row+1, 0) ... with a last flag.
// Latency: registered outputs, advance one step per cycle with en_i.
// Backpressure: holds while en_i is low; clr_i wins over en_i.
// Ports: clk, rst_n (async active-low), clr_i, en_i, row_o, col_o, last_o.
module rf_scan_counter #(
  parameter int ROWS = 28,
  parameter int HALF = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [5:0] row_o,
  output logic [5:0] col_o,
  output logic       last_o
);

  logic [5:0] row_q, row_d;
  logic       half_q, half_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      half_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      half_q <= half_d;
    end
  end

  assign last_o = half_q && (row_q == 6'(ROWS - 1));

  always_comb begin
    row_d  = row_q;
    half_d = half_q;
    if (clr_i) begin
      row_d  = '0;
      half_d = 1'b0;
    end else if (en_i) begin
      if (half_q) begin
        half_d = 1'b0;
        // wrap after the final beat so the address idles at the origin
        row_d  = last_o ? 6'd0 : row_q + 6'd1;
      end else begin
        half_d = 1'b1;
      end
    end
  end

  assign row_o = row_q;
  assign col_o = half_q ? 6'(HALF) : 6'd0;

endmodule

// File: rtl/conv_row_assembler.sv
// Collects half-rows of conv results from the RF selector into a flattened OHxOW feature map.
// Latency: zero-latency accept; a beat accepted at an edge is visible in fmap right after it.
// Backpressure: in_ready high for the whole RUN state; in_valid low simply stalls the scan.
// Ports: clk, reset (async active-low), start, sel (selector channel, master side),
//        busy (RUN or DONE), done (one-cycle completion pulse), fmap (assembled map).
module conv_row_assembler
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  conv_row_assembler_if.master                                 sel,
  output logic                                                 busy,
  output logic                                                 done,
  output logic [calc_oh(H, F)*calc_ow(W, F)*DATA_WIDTH-1:0]    fmap
);

  localparam int OH    = calc_oh(H, F);
  localparam int OW    = calc_ow(W, F);
  localparam int HALF  = calc_half(W, F);
  localparam int OFF_W = calc_off_w(H, W, F);

  state_e                     state_q, state_d;
  logic                       scan_clr;
  logic                       accept;
  logic                       last_beat;
  logic [5:0]                 row;
  logic [5:0]                 col;
  logic [OFF_W-1:0]           wr_off;
  logic [OH*OW*DATA_WIDTH-1:0] fmap_q;

  rf_scan_counter #(
    .ROWS (OH),
    .HALF (HALF)
  ) u_scan (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (scan_clr),
    .en_i   (accept),
    .row_o  (row),
    .col_o  (col),
    .last_o (last_beat)
  );

  assign accept        = sel.in_valid && sel.in_ready;
  assign sel.rowNumber = row;
  assign sel.column    = col;
  assign sel.in_ready  = (state_q == RUN);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    scan_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          scan_clr = 1'b1;
        end
      end
      RUN: begin
        if (accept && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Each operand widened before the multiply so the top row's offset cannot wrap.
  assign wr_off = OFF_W'(row) * OFF_W'(OW) + OFF_W'(col);

  // The map survives start; only reset clears it, each beat overwrites its own slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fmap_q <= '0;
    end else if (accept) begin
      fmap_q[int'(wr_off)*DATA_WIDTH +: HALF*DATA_WIDTH] <= sel.in_data;
    end
  end

  assign fmap = fmap_q;

endmodule

// File: tb/tb_conv_row_assembler.sv
module tb_conv_row_assembler;
  import cnn_pkg::*;

  localparam int DW    = 16;
  localparam int OH    = 28;
  localparam int OW    = 28;
  localparam int HALF  = 14;
  localparam int HW    = HALF * DW;
  localparam int NB    = 2 * OH;
  localparam int OHS   = 8;
  localparam int OWS   = 8;
  localparam int HALFS = 4;
  localparam int HWS   = HALFS * DW;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic start   = 1'b0;
  logic start_s = 1'b0;
  logic busy, done, busy_s, done_s;
  logic [OH*OW*DW-1:0]    fmap;
  logic [OHS*OWS*DW-1:0]  fmap_s;

  conv_row_assembler_if #(.DATA_WIDTH(DW), .HALF(HALF))  bus ();
  conv_row_assembler_if #(.DATA_WIDTH(DW), .HALF(HALFS)) bus_s ();

  conv_row_assembler #(.DATA_WIDTH(DW), .H(32), .W(32), .F(5)) dut (
    .clk(clk), .reset(rst_n), .start(start), .sel(bus),
    .busy(busy), .done(done), .fmap(fmap)
  );

  conv_row_assembler #(.DATA_WIDTH(DW), .H(12), .W(12), .F(5)) dut_s (
    .clk(clk), .reset(rst_n), .start(start_s), .sel(bus_s),
    .busy(busy_s), .done(done_s), .fmap(fmap_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int            off;
    logic [HW-1:0] dat;
  } beat_t;

  beat_t       sb[$];
  logic [15:0] exp_map [OH*OW];
  int          m_state = 0;   // 0 idle, 1 run, 2 done
  int          m_beat  = 0;
  int          gap_pct = 0;
  logic [15:0] base    = '0;
  int          ecnt    = 0;
  int          s_edge  = 0;
  int          dcnt    = 0;
  int          drel    = 0;

  function automatic logic [HW-1:0] beat_data(input int n, input logic [15:0] b);
    logic [HW-1:0] d;
    for (int j = 0; j < HALF; j++) d[j*DW +: DW] = 16'(n*HALF + j) + b;
    return d;
  endfunction

  function automatic logic [HWS-1:0] beat_data_s(input int n);
    logic [HWS-1:0] d;
    for (int j = 0; j < HALFS; j++) d[j*DW +: DW] = 16'(n*HALFS + j);
    return d;
  endfunction

  // Called at a falling edge: check this cycle, drive the next edge, advance the model.
  task automatic step(input bit want_start);
    beat_t e;
    bit    v;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("beat_fmap", 256'(fmap[e.off*DW +: HW]), 256'(e.dat));
    end
    check("in_ready", 256'(bus.in_ready), 256'(m_state == 1));
    check("busy", 256'(busy), 256'(m_state != 0));
    check("done", 256'(done), 256'(m_state == 2));
    if (m_state == 1) begin
      check("rowNumber", 256'(bus.rowNumber), 256'(m_beat / 2));
      check("column", 256'(bus.column), 256'((m_beat % 2) * HALF));
    end
    if (done) begin
      dcnt++;
      drel = ecnt - s_edge;
    end
    v            = ($urandom_range(99) >= gap_pct);
    start        = want_start;
    bus.in_valid = v;
    bus.in_data  = (m_state == 1 && v) ? beat_data(m_beat, base) : '1;
    case (m_state)
      0: if (want_start) begin
        m_state = 1;
        m_beat  = 0;
        s_edge  = ecnt;
      end
      1: if (v) begin
        e.off = m_beat * HALF;
        e.dat = beat_data(m_beat, base);
        sb.push_back(e);
        for (int j = 0; j < HALF; j++) exp_map[e.off + j] = 16'(e.off + j) + base;
        m_beat++;
        if (m_beat == NB) m_state = 2;
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic check_map(input string tag);
    int nb = 0;
    for (int p = 0; p < OH*OW; p++) if (fmap[p*DW +: DW] !== exp_map[p]) nb++;
    check(tag, 256'(nb), 256'(0));
  endtask

  task automatic run_scan(input logic [15:0] b, input int gp, input int pulse_beat,
                          input bit pulse_done, input bit keep_start);
    int guard = 0;
    base    = b;
    gap_pct = gp;
    dcnt    = 0;
    drel    = 0;
    step(1'b1);
    while (m_state != 0 && guard < 5000) begin
      step(keep_start || (m_state == 1 && m_beat == pulse_beat) || (m_state == 2 && pulse_done));
      guard++;
    end
    check("done_pulses", 256'(dcnt), 256'(1));
    if (gp == 0) check("done_cycle", 256'(drel), 256'(NB + 1));
    check_map("fmap_map");
  endtask

  task automatic run_abort(input int at);
    base    = 16'h0AA;
    gap_pct = 0;
    dcnt    = 0;
    step(1'b1);
    while (m_state == 1 && m_beat < at) step(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_no_done", 256'(dcnt), 256'(0));
    check("rst_in_ready", 256'(bus.in_ready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_row", 256'(bus.rowNumber), 256'(0));
    check("rst_col", 256'(bus.column), 256'(0));
    check("rst_fmap_any", 256'(|fmap), 256'(0));
    m_state = 0;
    m_beat  = 0;
    sb.delete();
    for (int p = 0; p < OH*OW; p++) exp_map[p] = '0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_small();
    int nb = 0;
    start_s        = 1'b1;
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = '1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) begin
        check("s_row", 256'(bus_s.rowNumber), 256'((c - 1) / 2));
        check("s_col", 256'(bus_s.column), 256'(((c - 1) % 2) * HALFS));
        bus_s.in_data = beat_data_s(c - 1);
      end else begin
        bus_s.in_data = '1;
      end
      check("s_done", 256'(done_s), 256'(c == 17));
      if (c == 18) check("s_busy_after", 256'(busy_s), 256'(0));
      @(posedge clk);
      @(negedge clk);
    end
    for (int p = 0; p < OHS*OWS; p++) if (fmap_s[p*DW +: DW] !== 16'(p)) nb++;
    check("s_map", 256'(nb), 256'(0));
  endtask

  initial begin
    for (int p = 0; p < OH*OW; p++) exp_map[p] = '0;
    bus.in_valid   = 1'b1;
    bus.in_data    = '1;
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = '1;
    #1 rst_n = 1'b0;
    #11;
    check("reset_row", 256'(bus.rowNumber), 256'(0));
    check("reset_col", 256'(bus.column), 256'(0));
    check("reset_in_ready", 256'(bus.in_ready), 256'(0));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_done", 256'(done), 256'(0));
    check("reset_fmap_any", 256'(|fmap), 256'(0));
    #11 rst_n = 1'b1;
    @(negedge clk);
    gap_pct = 0;
    for (int i = 0; i < 3; i++) step(1'b0);
    check("idle_fmap_any", 256'(|fmap), 256'(0));

    run_scan(16'h000, 30, -1, 1'b0, 1'b0);   // stalled scan from an empty map
    run_scan(16'h000, 0, -1, 1'b0, 1'b0);    // full-rate scan
    run_scan(16'h020, 0, 10, 1'b1, 1'b0);    // stray start pulses
    for (int i = 0; i < 3; i++) step(1'b0);
    run_scan(16'h040, 0, -1, 1'b0, 1'b1);    // start held: back-to-back
    run_scan(16'h040, 0, -1, 1'b0, 1'b1);
    step(1'b0);
    run_abort(30);
    run_scan(16'h100, 0, -1, 1'b0, 1'b0);
    run_small();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
